// File: rtl/serial_sum_collector.sv
// serial_sum_collector
// Result-side controller and deserializer for an N-bit Mealy serial adder.
// Sequences LOAD -> N x SHIFT -> DONE, assembles the LSB-first sum bits
// into a parallel word, captures the final carry and holds the result
// under a valid/ack handshake.

module serial_sum_collector #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_sum,
    input  logic         i_cout,
    input  logic         i_ack,
    output logic         o_ld,
    output logic         o_clr_c,
    output logic         o_shift,
    output logic         o_busy,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Count value seen during the final shift cycle.
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] count;
    logic [N-1:0]  sum_q;
    logic          cout_q;

    // Next-state decode; start is only honoured in IDLE, ack only in DONE.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (i_start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (count == LAST) next_state = DONE;
            DONE:    if (i_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset always lands in IDLE, discarding any result in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    // Datapath: clear on LOAD, shift in one sum bit per SHIFT cycle, grab carry on the last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    count  <= '0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                end
                SHIFT: begin
                    sum_q <= {i_sum, sum_q[N-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST) cout_q <= i_cout;
                end
                default: ;
            endcase
        end
    end

    // Control outputs come from the state register alone, so no input reaches them combinationally.
    assign o_ld    = (state == LOAD);
    assign o_clr_c = (state == LOAD);
    assign o_shift = (state == SHIFT);
    assign o_busy  = (state == LOAD) || (state == SHIFT);
    assign o_valid = (state == DONE);
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Testbench for serial_sum_collector.
// Directed operations push their expected {sum, cout} into a queue; a
// monitor pops and compares on every rising edge of o_valid.

module tb_serial_sum_collector;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic         i_sum;
    logic         i_cout;
    logic         i_ack;
    logic         o_ld;
    logic         o_clr_c;
    logic         o_shift;
    logic         o_busy;
    logic [N-1:0] o_sum;
    logic         o_cout;
    logic         o_valid;

    int checks   = 0;
    int failures = 0;
    int ld_cnt   = 0;
    int sh_cnt   = 0;
    int vld_cnt  = 0;

    logic [N:0] exp_q[$];

    serial_sum_collector #(.N(N), .CW(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .i_sum   (i_sum),
        .i_cout  (i_cout),
        .i_ack   (i_ack),
        .o_ld    (o_ld),
        .o_clr_c (o_clr_c),
        .o_shift (o_shift),
        .o_busy  (o_busy),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_ld, o_clr_c, o_shift, o_busy, o_valid, o_cout, o_sum});
    endfunction

    // Monitor: count strobe cycles and score each new result.
    initial begin
        logic vq;
        logic [N:0] e;
        vq = 1'b0;
        forever begin
            @(negedge clk);
            if (o_ld)    ld_cnt++;
            if (o_shift) sh_cnt++;
            if (o_valid) vld_cnt++;
            if (o_valid && !vq) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum",  32'(o_sum),  32'(e[N-1:0]));
                    check("sb_cout", 32'(o_cout), 32'(e[N]));
                end
            end
            vq = o_valid;
        end
    end

    // Raise start in IDLE, return just after edge t0 (DUT now in LOAD).
    task automatic start_op(input bit keep_start);
        @(posedge clk); #1;
        i_start = 1'b1;
        ld_cnt = 0;
        sh_cnt = 0;
        @(posedge clk); #1;
        if (!keep_start) i_start = 1'b0;
        check("load_strobes", 32'({o_ld, o_clr_c, o_busy, o_shift, o_valid}), 32'b11100);
    endtask

    // Present bits lo..hi of w, one per cycle; carry only with the last bit.
    task automatic drive_bits(input logic [N-1:0] w, input logic c, input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            @(posedge clk); #1;
            i_sum  = w[j];
            i_cout = (j == N - 1) ? c : 1'b0;
        end
    endtask

    // Full operation with optional DONE backpressure (start pulsed meanwhile).
    task automatic full_op(input string tag, input logic [N-1:0] w, input logic c, input int hold);
        logic [N-1:0] s;
        logic sc;
        start_op(1'b0);
        exp_q.push_back({c, w});
        drive_bits(w, c, 0, N - 1);
        @(posedge clk); #1;
        i_sum = 1'b0;
        i_cout = ~c;
        check({tag, "_valid_t0p9"}, 32'({o_valid, o_busy}), 32'b10);
        check({tag, "_ld_cycles"}, 32'(ld_cnt), 32'd1);
        check({tag, "_shift_cycles"}, 32'(sh_cnt), 32'(N));
        s = o_sum;
        sc = o_cout;
        for (int k = 0; k < hold; k++) begin
            i_start = k[0];
            i_ack = 1'b0;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'({o_valid, o_ld, o_busy}), 32'b100);
            check({tag, "_hold_data"}, 32'({o_cout, o_sum}), 32'({sc, s}));
        end
        i_start = 1'b0;
        i_ack = 1'b1;
        @(posedge clk); #1;
        i_ack = 1'b0;
        i_cout = 1'b0;
        check({tag, "_after_ack"}, 32'({o_valid, o_busy, o_ld}), 32'b000);
        check({tag, "_retained"}, 32'({o_cout, o_sum}), 32'({c, w}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_sum = 1'b0; i_cout = 1'b0; i_ack = 1'b0;

        // Reset with random inputs: every output forced to zero and held.
        #3;
        check("reset_outs_imm", all_outs(), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            {i_start, i_sum, i_cout, i_ack} = 4'($urandom);
            @(negedge clk);
            check("reset_outs_held", all_outs(), 32'd0);
        end
        @(posedge clk); #1;
        i_start = 1'b0; i_sum = 1'b0; i_cout = 1'b0; i_ack = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", all_outs(), 32'd0);
        i_ack = 1'b0;

        // Basic add 0x5A + 0x3C = 0x96, carry 0.
        full_op("basic", 8'h96, 1'b0, 0);

        // Carry out 0xFF + 0x01 = 0x00, carry 1.
        full_op("carry", 8'h00, 1'b1, 0);

        // Backpressure: 5 cycles without ack while start toggles.
        full_op("bp", 8'h6E, 1'b1, 5);
        // The next start after ack must be accepted.
        full_op("post_bp", 8'h31, 1'b0, 0);

        // Reset after 3 bits captured.
        start_op(1'b0);
        drive_bits(8'hFF, 1'b1, 0, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset_imm", all_outs(), 32'd0);
        @(negedge clk);
        check("midreset_held", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_sum = 1'b0;
        i_cout = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("midreset_idle", all_outs(), 32'd0);
        end

        // 0xA5 + 0x0F = 0xB4, carry 0.
        full_op("after_reset", 8'hB4, 1'b0, 0);

        // Back-to-back with start and ack held high: one result every 11 cycles.
        vld_cnt = 0;
        start_op(1'b1);
        i_ack = 1'b1;
        for (int op = 0; op < 3; op++) begin
            logic [N-1:0] w;
            w = (op == 0) ? 8'h3C : (op == 1) ? 8'hC3 : 8'h81;
            exp_q.push_back({1'b0, w});
            drive_bits(w, 1'b0, 0, N - 1);
            @(posedge clk); #1;
            check("b2b_valid_hi", 32'(o_valid), 32'd1);
            @(posedge clk); #1;
            check("b2b_valid_lo", 32'({o_valid, o_busy}), 32'b00);
            if (op < 2) begin
                @(posedge clk); #1;
                check("b2b_reload", 32'(o_ld), 32'd1);
            end
        end
        i_start = 1'b0;
        i_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_valid_cycles", 32'(vld_cnt), 32'd3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sum_collector.md
# serial_sum_collector

Result-side controller and deserializer for the 8-bit Mealy serial adder. On a start request it pulses load to the operand shift registers and clears the adder carry. It then enables exactly N shift cycles, assembling the LSB-first serial sum bits into a parallel word and capturing the final carry. The result is held under a valid/ack handshake toward the consumer.

## Interface
Parameters:
- N, 8, operand/result width in bits.
- CW, 4, bit counter width; must satisfy 2^CW > N.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset; one clock, asynchronous assertion, active-low.
- i_start  in  1  request a new addition; sampled only in IDLE.
- i_sum  in  1  serial sum bit from the Mealy adder, bit j valid in the j-th SHIFT cycle.
- i_cout  in  1  adder carry-out for the current bit (combinational from adder).
- i_ack  in  1  consumer accepts result; sampled only in DONE.
- o_ld  out  1  load strobe to operand shift registers.
- o_clr_c  out  1  clear strobe to the adder carry flip-flop.
- o_shift  out  1  shift enable to operand registers and adder carry flip-flop.
- o_busy  out  1  high in LOAD and SHIFT.
- o_sum  out  N  assembled sum, bit 0 = first serial bit.
- o_cout  out  1  carry-out of bit N-1.
- o_valid  out  1  result available.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- Reset value: state IDLE, count 0, o_sum 0, o_cout 0.
  - All strobes and o_valid/o_busy are 0.
- Control outputs (o_ld, o_clr_c, o_shift, o_busy, o_valid) are decoded from the state register only; there is no combinational input-to-output path.
- IDLE: i_start=1 -> LOAD; otherwise stay. i_ack ignored.
- LOAD (exactly 1 cycle):
  - o_ld=1, o_clr_c=1.
  - count <= 0, o_sum <= 0, o_cout <= 0.
  - Next state SHIFT.
- SHIFT (exactly N cycles):
  - o_shift=1.
  - Each edge: o_sum <= {i_sum, o_sum[N-1:1]}, count <= count+1.
  - On the edge where count == N-1: o_cout <= i_cout, state -> DONE.
  - i_start is ignored.
- DONE:
  - o_valid=1; o_sum and o_cout held stable.
  - i_ack=1 -> IDLE; i_start ignored.
- After ack, o_sum and o_cout retain their values until the next LOAD.
- Async reset in any state immediately forces all reset values; an in-flight result is discarded.

## Timing
- Let t0 be the edge sampling i_start=1 in IDLE.
- o_ld and o_clr_c are high for the single cycle between t0 and t0+1.
- o_shift is high for the cycles between t0+1 and t0+N+1.
  - Bit j is captured at edge t0+2+j.
  - i_cout is captured at edge t0+N+1.
- o_valid rises after edge t0+N+1 and stays high until the edge sampling i_ack=1; it is low from the following cycle.
- With i_start and i_ack both held high, one operation completes every N+3 cycles (IDLE 1 + LOAD 1 + SHIFT N + DONE 1).
- With N=8, that is 11 cycles.
- Releasing reset mid-operation always resumes in IDLE; a new start is required.

## Test plan
- Reset check: assert i_rst_n=0 with random inputs -> every output 0 immediately and held; release -> IDLE, o_busy=0.
- Basic add, 0x5A+0x3C: drive i_sum LSB-first with the bits of 0x96 and i_cout=0 on bit 7.
  - Expect o_ld for exactly 1 cycle and o_shift for exactly 8 cycles.
  - Expect o_valid after edge t0+9 with o_sum=0x96, o_cout=0.
- Carry-out, 0xFF+0x01: drive sum bits of 0x00 with i_cout=1 on bit 7 -> o_sum=0x00, o_cout=1.
- Backpressure: hold i_ack=0 for 5 cycles in DONE while pulsing i_start.
  - Expect o_valid=1 and o_sum/o_cout stable throughout; no LOAD.
  - Then i_ack=1 -> IDLE next cycle; the next i_start is accepted.
- Reset mid-SHIFT: assert i_rst_n=0 after 3 bits captured.
  - Expect outputs zeroed immediately, no o_valid.
  - A following full operation of 0xA5+0x0F yields o_sum=0xB4, o_cout=0.
- Back-to-back: hold i_start=1 and i_ack=1 across three operations -> o_valid is a 1-cycle pulse every 11 cycles, with correct o_sum each time.
